// File: rtl/colour_pkg.sv
// Shared palette data for the VGA colour output stage.
// Holds the RGB222 palette banks and the channel width helper.
package colour_pkg;

   localparam int NUM_BANKS   = 4;
   localparam int MAX_LAYERS  = 4;
   localparam int PAL_ENTRIES = MAX_LAYERS + 1;
   localparam int BANK_W      = $clog2(NUM_BANKS);

   typedef logic [5:0]        rgb222_t;
   typedef logic [BANK_W-1:0] bank_t;

   // {R[1:0], G[1:0], B[1:0]}; entry 0 is the per-bank background.
   localparam rgb222_t PALETTE [NUM_BANKS][PAL_ENTRIES] = '{
      '{6'b110000, 6'b111111, 6'b111100, 6'b001111, 6'b101010},
      '{6'b001100, 6'b111111, 6'b111100, 6'b001111, 6'b101010},
      '{6'b000011, 6'b111111, 6'b111100, 6'b001111, 6'b101010},
      '{6'b110011, 6'b111111, 6'b111100, 6'b001111, 6'b101010}
   };

   // Repeat a 2-bit channel so the top N bits give its MSB-replicated form.
   function automatic logic [3:0] widen_ch(input logic [1:0] c);
      return {c, c};
   endfunction

endpackage

// File: rtl/flash_timer.sv
// Frame-counted flash timer: a request arms a pending flag and the
// next frame_end (re)loads the counter; inversion lasts while nonzero.
module flash_timer
   import colour_pkg::*;
#(
   parameter int FLASH_FRAMES = 8
) (
   input  logic clk,
   input  logic reset,
   input  logic flash_req,
   input  logic frame_end,
   output logic flash_active,
   output logic invert
);

   localparam int CW = $clog2(FLASH_FRAMES + 1);
   localparam logic [CW-1:0] LOAD = CW'(FLASH_FRAMES);

   logic          pend_q, pend_d;
   logic [CW-1:0] cnt_q, cnt_d;

   // Arm on request, load or count down only at frame boundaries.
   always_comb begin
      pend_d = pend_q;
      cnt_d  = cnt_q;
      if (frame_end) begin
         if (pend_q || flash_req) begin
            cnt_d  = LOAD;
            pend_d = 1'b0;
         end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CW'(1);
         end
      end else if (flash_req) begin
         pend_d = 1'b1;
      end
   end

   // Timer state register.
   always_ff @(posedge clk) begin
      if (reset) begin
         pend_q <= 1'b0;
         cnt_q  <= '0;
      end else begin
         pend_q <= pend_d;
         cnt_q  <= cnt_d;
      end
   end

   assign flash_active = (cnt_q != '0);
   assign invert       = flash_active;

endmodule

// File: rtl/vga_colour_mixer.sv
// Two-stage colour output: layer priority, then frame-latched palette.
// Flash inversion is built only when VGA_COLOUR_MIXER_FLASH_EN is defined.
module vga_colour_mixer
   import colour_pkg::*;
#(
   parameter int   LAYERS       = 2,
   parameter int   COLOUR_BITS  = 2,
   parameter int   FLASH_FRAMES = 8,
   parameter logic SYNC_IDLE    = 1'b1
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [LAYERS-1:0]      pixel_layers,
   input  logic                   video_active,
   input  logic                   hsync_in,
   input  logic                   vsync_in,
   input  logic                   frame_end,
   input  logic [1:0]             palette_sel,
   input  logic                   flash_req,
   output logic [COLOUR_BITS-1:0] R,
   output logic [COLOUR_BITS-1:0] G,
   output logic [COLOUR_BITS-1:0] B,
   output logic                   hsync_out,
   output logic                   vsync_out,
   output logic                   flash_active
);

   localparam int IW = $clog2(LAYERS + 1);

   logic          invert;

   logic [IW-1:0] idx_q, idx_d;
   logic          va_q, va_d;
   logic          hs1_q, hs1_d;
   logic          vs1_q, vs1_d;
   bank_t         bank_q, bank_d;
   bank_t         s1_bank_q, s1_bank_d;

   logic [COLOUR_BITS-1:0] r_q, r_d;
   logic [COLOUR_BITS-1:0] g_q, g_d;
   logic [COLOUR_BITS-1:0] b_q, b_d;
   logic                   hs2_q, hs2_d;
   logic                   vs2_q, vs2_d;

   rgb222_t    entry;
   logic [3:0] r4, g4, b4;

`ifdef VGA_COLOUR_MIXER_FLASH_EN
   flash_timer #(
      .FLASH_FRAMES(FLASH_FRAMES)
   ) u_flash (
      .clk         (clk),
      .reset       (reset),
      .flash_req   (flash_req),
      .frame_end   (frame_end),
      .flash_active(flash_active),
      .invert      (invert)
   );
`else
   logic unused_flash;
   assign unused_flash = flash_req ^ (FLASH_FRAMES == 0);
   assign flash_active = 1'b0;
   assign invert       = 1'b0;
`endif

   // Stage 1 next state: highest set layer wins; bank latches at frame end.
   always_comb begin
      idx_d = '0;
      for (int k = 0; k < LAYERS; k++) begin
         if (pixel_layers[k]) idx_d = IW'(k + 1);
      end
      va_d      = video_active;
      hs1_d     = hsync_in;
      vs1_d     = vsync_in;
      s1_bank_d = bank_q;
      bank_d    = frame_end ? bank_t'(palette_sel) : bank_q;
   end

   // Stage 1 and active bank registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         idx_q     <= '0;
         va_q      <= 1'b0;
         hs1_q     <= SYNC_IDLE;
         vs1_q     <= SYNC_IDLE;
         s1_bank_q <= '0;
         bank_q    <= '0;
      end else begin
         idx_q     <= idx_d;
         va_q      <= va_d;
         hs1_q     <= hs1_d;
         vs1_q     <= vs1_d;
         s1_bank_q <= s1_bank_d;
         bank_q    <= bank_d;
      end
   end

   // Stage 2 next state: palette lookup, width scaling, flash, blanking.
   always_comb begin
      entry = PALETTE[s1_bank_q][3'(idx_q)];
      r4    = widen_ch(entry[5:4]);
      g4    = widen_ch(entry[3:2]);
      b4    = widen_ch(entry[1:0]);
      r_d   = r4[3 -: COLOUR_BITS];
      g_d   = g4[3 -: COLOUR_BITS];
      b_d   = b4[3 -: COLOUR_BITS];
      if (invert) begin
         r_d = ~r_d;
         g_d = ~g_d;
         b_d = ~b_d;
      end
      if (!va_q) begin
         r_d = '0;
         g_d = '0;
         b_d = '0;
      end
      hs2_d = hs1_q;
      vs2_d = vs1_q;
   end

   // Stage 2 output registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_q   <= '0;
         g_q   <= '0;
         b_q   <= '0;
         hs2_q <= SYNC_IDLE;
         vs2_q <= SYNC_IDLE;
      end else begin
         r_q   <= r_d;
         g_q   <= g_d;
         b_q   <= b_d;
         hs2_q <= hs2_d;
         vs2_q <= vs2_d;
      end
   end

   assign R         = r_q;
   assign G         = g_q;
   assign B         = b_q;
   assign hsync_out = hs2_q;
   assign vsync_out = vs2_q;

endmodule

// File: tb/tb_vga_colour_mixer.sv
// Randomised bench for vga_colour_mixer against a cycle reference model.
// Flash expectations follow VGA_COLOUR_MIXER_FLASH_EN.
module tb_vga_colour_mixer;

   localparam int   LAYERS = 2;
   localparam int   CB     = 2;
   localparam int   FF     = 8;
   localparam logic IDLE   = 1'b1;
   localparam int   NCYC   = 3000;
`ifdef VGA_COLOUR_MIXER_FLASH_EN
   localparam bit FLASH_EN = 1'b1;
`else
   localparam bit FLASH_EN = 1'b0;
`endif

   logic              clk = 1'b0;
   logic              reset = 1'b1;
   logic [LAYERS-1:0] pixel_layers = '0;
   logic              video_active = 1'b0;
   logic              hsync_in = 1'b0;
   logic              vsync_in = 1'b0;
   logic              frame_end = 1'b0;
   logic [1:0]        palette_sel = '0;
   logic              flash_req = 1'b0;
   logic [CB-1:0]     R, G, B;
   logic              hsync_out, vsync_out, flash_active;

   vga_colour_mixer #(
      .LAYERS      (LAYERS),
      .COLOUR_BITS (CB),
      .FLASH_FRAMES(FF),
      .SYNC_IDLE   (IDLE)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .pixel_layers(pixel_layers),
      .video_active(video_active),
      .hsync_in    (hsync_in),
      .vsync_in    (vsync_in),
      .frame_end   (frame_end),
      .palette_sel (palette_sel),
      .flash_req   (flash_req),
      .R           (R),
      .G           (G),
      .B           (B),
      .hsync_out   (hsync_out),
      .vsync_out   (vsync_out),
      .flash_active(flash_active)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int passed = 0;

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      checks++;
      if (got === exp) passed++;
      else $display("FAIL %s t=%0t got=%h exp=%h", tag, $time, got, exp);
   endtask

   // Colour named by the palette description, as RGB222.
   function automatic logic [5:0] ref_rgb(input int bank, input int idx);
      case (idx)
         0: case (bank)
               0:       return 6'b11_00_00;
               1:       return 6'b00_11_00;
               2:       return 6'b00_00_11;
               default: return 6'b11_00_11;
            endcase
         1:       return 6'b11_11_11;
         2:       return 6'b11_11_00;
         3:       return 6'b00_11_11;
         default: return 6'b10_10_10;
      endcase
   endfunction

   function automatic logic [CB-1:0] ref_scale(input logic [1:0] c);
      logic [7:0] rep;
      rep = {4{c}};
      return CB'(rep >> (8 - CB));
   endfunction

   function automatic int ref_idx(input logic [LAYERS-1:0] pl);
      for (int k = LAYERS - 1; k >= 0; k--) if (pl[k]) return k + 1;
      return 0;
   endfunction

   localparam int EW = 3 * CB + 2;

   int             bank, cnt, idx;
   bit             pend;
   logic [5:0]     c6;
   logic [CB-1:0]  r, g, b;
   logic [EW-1:0]  prev_entry, entry, exp_out;
   logic           fa_exp;

   initial begin
      bank = 0;
      cnt = 0;
      pend = 1'b0;
      prev_entry = {{(3*CB){1'b0}}, IDLE, IDLE};
      for (int cyc = 0; cyc < NCYC; cyc++) begin
         reset        = (cyc < 3) || ($urandom_range(0, 299) == 0);
         pixel_layers = LAYERS'($urandom_range(0, (1 << LAYERS) - 1));
         video_active = ($urandom_range(0, 9) != 0);
         hsync_in     = 1'($urandom_range(0, 1));
         vsync_in     = 1'($urandom_range(0, 1));
         frame_end    = ($urandom_range(0, 9) == 0);
         palette_sel  = 2'($urandom_range(0, 3));
         flash_req    = ($urandom_range(0, 29) == 0);
         @(posedge clk);
         #1;
         if (reset) begin
            bank    = 0;
            cnt     = 0;
            pend    = 1'b0;
            entry   = {{(3*CB){1'b0}}, IDLE, IDLE};
            exp_out = entry;
         end else begin
            idx = ref_idx(pixel_layers);
            c6  = ref_rgb(bank, idx);
            if (frame_end) bank = int'(palette_sel);
            if (FLASH_EN) begin
               if (frame_end) begin
                  if (pend || flash_req) begin
                     cnt  = FF;
                     pend = 1'b0;
                  end else if (cnt > 0) begin
                     cnt = cnt - 1;
                  end
               end else if (flash_req) begin
                  pend = 1'b1;
               end
            end
            r = ref_scale(c6[5:4]);
            g = ref_scale(c6[3:2]);
            b = ref_scale(c6[1:0]);
            if (cnt > 0) begin
               r = ~r;
               g = ~g;
               b = ~b;
            end
            if (!video_active) begin
               r = '0;
               g = '0;
               b = '0;
            end
            exp_out = prev_entry;
            entry   = {r, g, b, hsync_in, vsync_in};
         end
         prev_entry = entry;
         fa_exp = (cnt != 0);
         check(reset ? "reset" : (fa_exp ? "flash" : "pixel"),
               32'({R, G, B, hsync_out, vsync_out, flash_active}),
               32'({exp_out, fa_exp}));
      end
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
